// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay trip controller: channel FSM state
// encoding and the width helpers used to size ports and counters.
package relay_pkg;

  localparam logic [1:0] ST_WAIT_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_PEND_ENC = 2'd2;
  localparam logic [1:0] ST_TRIP_ENC = 2'd3;

  typedef enum logic [1:0] {
    WAIT = ST_WAIT_ENC,
    RUN  = ST_RUN_ENC,
    PEND = ST_PEND_ENC,
    TRIP = ST_TRIP_ENC
  } relay_state_e;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 32'sd1) ? $clog2(num_ch) : 32'sd1;
  endfunction

  // Over-threshold counter width: must hold TRIP_CNT itself.
  function automatic int cnt_width(input int trip_cnt);
    return (trip_cnt > 32'sd1) ? $clog2(trip_cnt + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/relay_ch_fsm.sv
// One relay channel: debounce counter, below flag and latching trip FSM.
// Optional RELAY_HYST_EN adds a re-arm hysteresis margin of HYST LSBs.
module relay_ch_fsm
  import relay_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                TRIP_CNT = 4,
  parameter logic [DATA_W-1:0] HYST     = DATA_W'(16'h0100)
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              smp_acc,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [DATA_W-1:0] thresh,
  input  logic              override,
  input  logic              rearm,
  output logic              trigger_r,
  output logic              tripped_r,
  output logic              trip_pulse_r
);

  localparam int               CNT_W      = cnt_width(TRIP_CNT);
  localparam logic [CNT_W:0]   TRIP_CNT_C = (CNT_W + 1)'(TRIP_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

`ifdef RELAY_HYST_EN
  localparam logic [DATA_W-1:0] MARGIN_C = HYST;
`else
  // With zero margin the below test collapses to !over.
  localparam logic [DATA_W-1:0] MARGIN_C = HYST & {DATA_W{1'b0}};
`endif

  relay_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             below_r;

  logic             over_s;
  logic             below_s;
  logic             below_q_s;
  logic [DATA_W:0]  below_sum_s;
  logic [CNT_W:0]   cnt_inc_s;

  assign over_s      = smp_data > thresh;
  assign below_sum_s = {1'b0, smp_data} + {1'b0, MARGIN_C};
  assign below_s     = below_sum_s <= {1'b0, thresh};
  assign below_q_s   = smp_acc ? below_s : below_r;
  assign cnt_inc_s   = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Channel FSM with registered relay enable, trip status and trip pulse
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_r      <= WAIT;
      cnt_r        <= {CNT_W{1'b0}};
      below_r      <= 1'b0;
      trigger_r    <= 1'b0;
      tripped_r    <= 1'b0;
      trip_pulse_r <= 1'b0;
    end else begin
      trip_pulse_r <= 1'b0;
      if (smp_acc) begin
        below_r <= below_s;
      end else begin
        below_r <= below_r;
      end
      case (state_r)
        WAIT: begin
          if (smp_acc && below_s) begin
            state_r   <= RUN;
            trigger_r <= 1'b1;
          end else begin
            trigger_r <= override;
          end
        end
        RUN: begin
          if (smp_acc && over_s) begin
            if (TRIP_CNT == 32'sd1) begin
              state_r      <= TRIP;
              tripped_r    <= 1'b1;
              trip_pulse_r <= 1'b1;
              trigger_r    <= override;
            end else begin
              state_r   <= PEND;
              cnt_r     <= CNT_ONE_C;
              trigger_r <= 1'b1;
            end
          end else begin
            trigger_r <= 1'b1;
          end
        end
        PEND: begin
          if (smp_acc && over_s && (cnt_inc_s == TRIP_CNT_C)) begin
            state_r      <= TRIP;
            cnt_r        <= {CNT_W{1'b0}};
            tripped_r    <= 1'b1;
            trip_pulse_r <= 1'b1;
            trigger_r    <= override;
          end else if (smp_acc && over_s) begin
            cnt_r     <= cnt_inc_s[CNT_W-1:0];
            trigger_r <= 1'b1;
          end else if (smp_acc) begin
            state_r   <= RUN;
            cnt_r     <= {CNT_W{1'b0}};
            trigger_r <= 1'b1;
          end else begin
            trigger_r <= 1'b1;
          end
        end
        TRIP: begin
          // Re-arm qualifies on this cycle's sample if any, else the stored flag.
          if (rearm && below_q_s) begin
            state_r   <= RUN;
            tripped_r <= 1'b0;
            trigger_r <= 1'b1;
          end else begin
            trigger_r <= override;
          end
        end
        default: begin
          state_r   <= WAIT;
          cnt_r     <= {CNT_W{1'b0}};
          tripped_r <= 1'b0;
          trigger_r <= override;
        end
      endcase
    end
  end

endmodule

// File: rtl/relay_trip_ctrl.sv
// Multi-channel relay trip controller: decodes the XADC sample stream into
// per-channel FSMs. Optional RELAY_HYST_EN enables re-arm hysteresis.
module relay_trip_ctrl
  import relay_pkg::*;
#(
  parameter int                NUM_CH   = 4,
  parameter int                DATA_W   = 16,
  parameter int                TRIP_CNT = 4,
  parameter logic [DATA_W-1:0] HYST     = DATA_W'(16'h0100),
  localparam int               CH_W     = ch_width(NUM_CH)
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset,
  input  logic                     smp_valid,
  input  logic [CH_W-1:0]          smp_ch,
  input  logic [DATA_W-1:0]        smp_data,
  input  logic [NUM_CH*DATA_W-1:0] trip_thresh,
  input  logic [NUM_CH-1:0]        override,
  input  logic [NUM_CH-1:0]        rearm,
  output logic [NUM_CH-1:0]        trigger,
  output logic [NUM_CH-1:0]        tripped,
  output logic                     trip_event
);

  // Compared one bit wider so NUM_CH == 2**CH_W does not truncate.
  localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

  logic              ch_ok_s;
  logic [NUM_CH-1:0] acc_s;
  logic [NUM_CH-1:0] pulse_s;

  assign ch_ok_s = smp_valid && ({1'b0, smp_ch} < NUM_CH_C);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign acc_s[c] = ch_ok_s && (smp_ch == CH_W'(c));

    relay_ch_fsm #(
      .DATA_W   (DATA_W),
      .TRIP_CNT (TRIP_CNT),
      .HYST     (HYST)
    ) u_ch (
      .CLK100MHZ    (CLK100MHZ),
      .reset        (reset),
      .smp_acc      (acc_s[c]),
      .smp_data     (smp_data),
      .thresh       (trip_thresh[c*DATA_W +: DATA_W]),
      .override     (override[c]),
      .rearm        (rearm[c]),
      .trigger_r    (trigger[c]),
      .tripped_r    (tripped[c]),
      .trip_pulse_r (pulse_s[c])
    );
  end

  // At most one channel is sampled per cycle, so the pulses never overlap.
  assign trip_event = |pulse_s;

endmodule

// File: tb/tb_relay_trip_ctrl.sv
// Self-checking bench for relay_trip_ctrl (NUM_CH=3, TRIP_CNT=3, HYST=0x40):
// directed vector table, multi-cycle sequences, then randomized traffic.
module tb_relay_trip_ctrl;

  localparam int          NUM_CH   = 3;
  localparam int          DATA_W   = 16;
  localparam int          TRIP_CNT = 3;
  localparam int          CH_W     = 2;
  localparam logic [15:0] HYST     = 16'h0040;

  logic              CLK100MHZ = 1'b0;
  logic              reset     = 1'b1;
  logic              smp_valid = 1'b0;
  logic [CH_W-1:0]   smp_ch    = 2'd0;
  logic [15:0]       smp_data  = 16'h0000;
  logic [47:0]       trip_thresh = 48'h0;
  logic [2:0]        override  = 3'b000;
  logic [2:0]        rearm     = 3'b000;
  logic [2:0]        trigger;
  logic [2:0]        tripped;
  logic              trip_event;

  always #5 CLK100MHZ = ~CLK100MHZ;

  relay_trip_ctrl #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .TRIP_CNT (TRIP_CNT),
    .HYST     (HYST)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset       (reset),
    .smp_valid   (smp_valid),
    .smp_ch      (smp_ch),
    .smp_data    (smp_data),
    .trip_thresh (trip_thresh),
    .override    (override),
    .rearm       (rearm),
    .trigger     (trigger),
    .tripped     (tripped),
    .trip_event  (trip_event)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: relay armed flag, latched trip flag, over-sample streak.
  bit         m_armed [NUM_CH];
  bit         m_trip  [NUM_CH];
  bit         m_below [NUM_CH];
  int         m_streak[NUM_CH];
  bit         m_evt;
  logic [2:0] m_trig_v;
  logic [2:0] m_trip_v;

  function automatic bit below_rule(input logic [15:0] d, input logic [15:0] t);
`ifdef RELAY_HYST_EN
    return (int'(d) + int'(HYST)) <= int'(t);
`else
    return int'(d) <= int'(t);
`endif
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_armed[c] = 1'b0; m_trip[c] = 1'b0; m_below[c] = 1'b0; m_streak[c] = 0;
    end
    m_evt = 1'b0; m_trig_v = 3'b000; m_trip_v = 3'b000;
  endtask

  task automatic m_step();
    m_evt = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [15:0] t;
      bit acc, over, below, qual;
      t     = trip_thresh[c*DATA_W +: DATA_W];
      acc   = smp_valid && (int'(smp_ch) == c);
      over  = int'(smp_data) > int'(t);
      below = below_rule(smp_data, t);
      qual  = acc ? below : m_below[c];
      if (m_trip[c]) begin
        if (rearm[c] && qual) begin
          m_trip[c] = 1'b0; m_armed[c] = 1'b1; m_streak[c] = 0;
        end
      end else if (!m_armed[c]) begin
        if (acc && below) m_armed[c] = 1'b1;
      end else if (acc) begin
        if (over) begin
          m_streak[c]++;
          if (m_streak[c] >= TRIP_CNT) begin
            m_trip[c] = 1'b1; m_armed[c] = 1'b0; m_streak[c] = 0; m_evt = 1'b1;
          end
        end else begin
          m_streak[c] = 0;
        end
      end
      if (acc) m_below[c] = below;
      m_trig_v[c] = m_armed[c] | override[c];
      m_trip_v[c] = m_trip[c];
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    if (reset) m_reset(); else m_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic smp(input logic [1:0] ch, input logic [15:0] d);
    smp_valid = 1'b1; smp_ch = ch; smp_data = d;
    tick();
    smp_valid = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [15:0] d;
    logic [2:0]  ovr;
    logic [2:0]  ra;
    logic [2:0]  e_trig;
    logic [2:0]  e_trip;
    logic        e_evt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [15:0] d,
                              input logic [2:0] ovr, input logic [2:0] ra,
                              input logic [2:0] et, input logic [2:0] ep, input logic ee);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.ovr = ovr; r.ra = ra;
    r.e_trig = et; r.e_trip = ep; r.e_evt = ee;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [15:0] thr[4];

    tbl.push_back(mk(1'b1, 2'd0, 16'h0100, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0100, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0100, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b001, 3'b010, 1'b1));
    tbl.push_back(mk(1'b0, 2'd1, 16'h0900, 3'b000, 3'b000, 3'b001, 3'b010, 1'b0));
    tbl.push_back(mk(1'b0, 2'd1, 16'h0900, 3'b000, 3'b010, 3'b001, 3'b010, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0900, 3'b000, 3'b010, 3'b001, 3'b010, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 16'h0100, 3'b000, 3'b010, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 16'h0800, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 16'h0800, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 16'h0800, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 16'hFFFF, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));
    tbl.push_back(mk(1'b0, 2'd2, 16'h0900, 3'b100, 3'b000, 3'b111, 3'b000, 1'b0));
    tbl.push_back(mk(1'b0, 2'd2, 16'h0900, 3'b000, 3'b000, 3'b011, 3'b000, 1'b0));

    trip_thresh = {16'h0800, 16'h0800, 16'h0800};
    m_reset();
    tick();
    tick();
    chk("reset trigger", 32'(trigger), 32'h0);
    chk("reset tripped", 32'(tripped), 32'h0);
    chk("reset trip_event", 32'(trip_event), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      smp_valid = tbl[i].v; smp_ch = tbl[i].ch; smp_data = tbl[i].d;
      override = tbl[i].ovr; rearm = tbl[i].ra;
      tick();
      chk($sformatf("vec%0d trigger", i), 32'(trigger), 32'(tbl[i].e_trig));
      chk($sformatf("vec%0d tripped", i), 32'(tripped), 32'(tbl[i].e_trip));
      chk($sformatf("vec%0d trip_event", i), 32'(trip_event), 32'(tbl[i].e_evt));
    end
    smp_valid = 1'b0; override = 3'b000; rearm = 3'b000;

    // Trip while overridden, then release override.
    smp(2'd2, 16'h0100);
    chk("ovr arm trigger", 32'(trigger), 32'h7);
    override = 3'b100;
    smp(2'd2, 16'h0900);
    smp(2'd2, 16'h0900);
    smp(2'd2, 16'h0900);
    chk("ovr trip tripped", 32'(tripped[2]), 32'h1);
    chk("ovr trip trigger", 32'(trigger[2]), 32'h1);
    chk("ovr trip event", 32'(trip_event), 32'h1);
    tick();
    chk("ovr event width", 32'(trip_event), 32'h0);
    override = 3'b000;
    tick();
    chk("ovr release trigger", 32'(trigger[2]), 32'h0);
    chk("ovr release tripped", 32'(tripped[2]), 32'h1);
    override = 3'b100;
    tick();
    chk("ovr on tripped trigger", 32'(trigger[2]), 32'h1);
    override = 3'b000;
    tick();

    // Asynchronous reset in the middle of the debounce window.
    smp(2'd0, 16'h0900);
    chk("pend trigger", 32'(trigger[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset trigger", 32'(trigger), 32'h0);
    chk("async reset tripped", 32'(tripped), 32'h0);
    m_reset();
    tick();
    reset = 1'b0;
    smp(2'd0, 16'h0100);
    smp(2'd0, 16'h0900);
    smp(2'd0, 16'h0900);
    chk("post reset no early trip", 32'(tripped[0]), 32'h0);
    smp(2'd0, 16'h0900);
    chk("post reset trip", 32'(tripped[0]), 32'h1);
    chk("post reset trigger off", 32'(trigger[0]), 32'h0);

    rearm = 3'b001;
    smp(2'd0, 16'h07F0);
`ifdef RELAY_HYST_EN
    chk("hyst rearm rejected", 32'(tripped[0]), 32'h1);
    smp(2'd0, 16'h07C0);
    chk("hyst rearm accepted", 32'(tripped[0]), 32'h0);
    chk("hyst rearm trigger", 32'(trigger[0]), 32'h1);
    rearm = 3'b000;
    smp(2'd1, 16'h07F0);
    chk("hyst wait stays", 32'(trigger[1]), 32'h0);
    trip_thresh[47:32] = 16'h0020;
    smp(2'd2, 16'h0000);
    chk("hyst small thresh", 32'(trigger[2]), 32'h0);
`else
    chk("rearm below accepted", 32'(tripped[0]), 32'h0);
    chk("rearm trigger", 32'(trigger[0]), 32'h1);
    rearm = 3'b000;
    smp(2'd1, 16'h07F0);
    chk("wait to run", 32'(trigger[1]), 32'h1);
`endif

    // Randomized traffic against the reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          thr[c] = 16'($urandom_range(32'h0080, 32'hFF00));
          if ($urandom_range(0, 3) == 0) thr[c] = 16'($urandom_range(0, 32'h003F));
        end
        thr[3] = 16'h8000;
        trip_thresh = {thr[2], thr[1], thr[0]};
      end
      begin
        int ch, d;
        ch = int'($urandom_range(0, 3));
        d  = int'(thr[ch]) + int'($urandom_range(0, 256)) - 128;
        if ($urandom_range(0, 7) == 0) d = int'(thr[ch]);
        if (d < 0) d = 0;
        if (d > 65535) d = 65535;
        smp_valid = ($urandom_range(0, 1) == 1);
        smp_ch    = 2'(ch);
        smp_data  = 16'(d);
        rearm     = 3'($urandom) & 3'($urandom);
        if ($urandom_range(0, 15) == 0) override = override ^ 3'(1 << $urandom_range(0, 2));
      end
      tick();
      chk("rand trigger", 32'(trigger), 32'(m_trig_v));
      chk("rand tripped", 32'(tripped), 32'(m_trip_v));
      chk("rand trip_event", 32'(trip_event), 32'(m_evt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
